// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared op codes, ROB alias type, entry layout and CDB snoop helper for the ALU reservation station
package rs_alu_pkg;
   localparam int RS_SIZE = 8;
   localparam int RS_IDX_WIDTH = 3;
   localparam int ROB_WIDTH = 4;
   typedef logic [ROB_WIDTH-1:0] rob_id_t;
   typedef enum logic [4:0] {
      NOP, OPTYPE_ADD, OPTYPE_SUB, OPTYPE_AND, OPTYPE_OR, OPTYPE_XOR, OPTYPE_SLL, OPTYPE_SRL,
      OPTYPE_SRA, OPTYPE_SLT, OPTYPE_SLTU, OPTYPE_ADDI, OPTYPE_ANDI, OPTYPE_ORI, OPTYPE_XORI,
      OPTYPE_SLLI, OPTYPE_SRLI, OPTYPE_SRAI, OPTYPE_SLTI, OPTYPE_SLTIU, OPTYPE_BEQ, OPTYPE_BNE,
      OPTYPE_BLT, OPTYPE_BGE, OPTYPE_BLTU, OPTYPE_BGEU, OPTYPE_JAL, OPTYPE_JALR, OPTYPE_LUI,
      OPTYPE_AUIPC
   } opcode_type_t;
   typedef struct packed {
      logic         busy;
      opcode_type_t optype;
      rob_id_t      rd;
      logic [31:0]  pc;
      logic [31:0]  imm;
      logic [31:0]  vj;
      logic [31:0]  vk;
      logic         rj;
      logic         rk;
      rob_id_t      qj;
      rob_id_t      qk;
   } rs_entry_t;
   // {ready, value} of an operand after looking at both broadcast buses; ALU bus wins a tie
   function automatic logic [32:0] snoop(input logic rdy, input rob_id_t q, input logic [31:0] v,
                                         input logic av, input rob_id_t aa, input logic [31:0] ad,
                                         input logic lv, input rob_id_t la, input logic [31:0] ld);
      return rdy ? {1'b1, v} : (av && aa == q) ? {1'b1, ad} : (lv && la == q) ? {1'b1, ld} : {1'b0, v};
   endfunction
endpackage

// File: rtl/rs_alu_select.sv
// rs_alu_select: lowest-index priority encoder with found flag
module rs_alu_select #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);
   always_comb begin
      idx = '0;
      found = |req;
      for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
   end
endmodule

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station, snoops ALU/LSB CDBs and issues the lowest-index ready entry each cycle.
// Optional RS_WAKEUP_BYPASS_EN lets select see same-cycle CDB hits, issuing one cycle earlier.
module rs_alu
   import rs_alu_pkg::*;
#(
   parameter int RS_SIZE = rs_alu_pkg::RS_SIZE,
   parameter int RS_IDX_WIDTH = rs_alu_pkg::RS_IDX_WIDTH
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   input  logic         rdy_in,
   input  logic         clear_in,
   input  logic         disp_valid_in,
   input  opcode_type_t disp_optype_in,
   input  rob_id_t      disp_rd_in,
   input  logic [31:0]  disp_pc_in,
   input  logic [31:0]  disp_imm_in,
   input  logic [31:0]  disp_vj_in,
   input  logic [31:0]  disp_vk_in,
   input  logic         disp_qj_rdy_in,
   input  logic         disp_qk_rdy_in,
   input  rob_id_t      disp_qj_in,
   input  rob_id_t      disp_qk_in,
   input  logic         alu_cdb_valid_in,
   input  rob_id_t      alu_cdb_alias_in,
   input  logic [31:0]  alu_cdb_value_in,
   input  logic         lsb_cdb_valid_in,
   input  rob_id_t      lsb_cdb_alias_in,
   input  logic [31:0]  lsb_cdb_value_in,
   output logic         full_out,
   output opcode_type_t ex_optype_out,
   output rob_id_t      ex_rd_out,
   output logic [31:0]  ex_pc_out,
   output logic [31:0]  ex_rs1_out,
   output logic [31:0]  ex_rs2_out,
   output logic [31:0]  ex_imm_out
);
   rs_entry_t ent [RS_SIZE];
   logic [32:0] nj [RS_SIZE];
   logic [32:0] nk [RS_SIZE];
   logic [RS_SIZE-1:0] busy, ready;
   logic [32:0] dj, dk;
   logic [RS_IDX_WIDTH-1:0] free_idx, sel_idx;
   logic free_found, sel_found, accept;
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         busy[i] = ent[i].busy;
         nj[i] = snoop(ent[i].rj, ent[i].qj, ent[i].vj, alu_cdb_valid_in, alu_cdb_alias_in,
                       alu_cdb_value_in, lsb_cdb_valid_in, lsb_cdb_alias_in, lsb_cdb_value_in);
         nk[i] = snoop(ent[i].rk, ent[i].qk, ent[i].vk, alu_cdb_valid_in, alu_cdb_alias_in,
                       alu_cdb_value_in, lsb_cdb_valid_in, lsb_cdb_alias_in, lsb_cdb_value_in);
`ifdef RS_WAKEUP_BYPASS_EN
         ready[i] = ent[i].busy & nj[i][32] & nk[i][32];
`else
         ready[i] = ent[i].busy & ent[i].rj & ent[i].rk;
`endif
      end
   end
   assign dj = snoop(disp_qj_rdy_in, disp_qj_in, disp_vj_in, alu_cdb_valid_in, alu_cdb_alias_in,
                     alu_cdb_value_in, lsb_cdb_valid_in, lsb_cdb_alias_in, lsb_cdb_value_in);
   assign dk = snoop(disp_qk_rdy_in, disp_qk_in, disp_vk_in, alu_cdb_valid_in, alu_cdb_alias_in,
                     alu_cdb_value_in, lsb_cdb_valid_in, lsb_cdb_alias_in, lsb_cdb_value_in);
   assign full_out = &busy;
   assign accept = disp_valid_in & ~full_out;
   rs_alu_select #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_free (.req(~busy), .idx(free_idx), .found(free_found));
   rs_alu_select #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_sel (.req(ready), .idx(sel_idx), .found(sel_found));
   // operand values always come from the snooped view; it equals the stored value once ready
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
         ex_optype_out <= NOP;
         ex_rd_out <= '0;
         ex_pc_out <= '0;
         ex_rs1_out <= '0;
         ex_rs2_out <= '0;
         ex_imm_out <= '0;
      end else if (!rdy_in) begin
         ex_optype_out <= NOP;
      end else if (clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
         ex_optype_out <= NOP;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (ent[i].busy) begin
               ent[i].rj <= nj[i][32];
               ent[i].vj <= nj[i][31:0];
               ent[i].rk <= nk[i][32];
               ent[i].vk <= nk[i][31:0];
            end
         end
         ex_optype_out <= sel_found ? ent[sel_idx].optype : NOP;
         if (sel_found) begin
            ent[sel_idx].busy <= 1'b0;
            ex_rd_out <= ent[sel_idx].rd;
            ex_pc_out <= ent[sel_idx].pc;
            ex_rs1_out <= nj[sel_idx][31:0];
            ex_rs2_out <= nk[sel_idx][31:0];
            ex_imm_out <= ent[sel_idx].imm;
         end
         if (accept && free_found)
            ent[free_idx] <= '{busy: 1'b1, optype: disp_optype_in, rd: disp_rd_in, pc: disp_pc_in,
                               imm: disp_imm_in, vj: dj[31:0], vk: dk[31:0], rj: dj[32], rk: dk[32],
                               qj: disp_qj_in, qk: disp_qk_in};
      end
   end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed self-checking bench for rs_alu
module tb_rs_alu;
   import rs_alu_pkg::*;
   logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0;
   logic disp_valid_in, disp_qj_rdy_in, disp_qk_rdy_in;
   opcode_type_t disp_optype_in, ex_optype_out;
   rob_id_t disp_rd_in, disp_qj_in, disp_qk_in, alu_cdb_alias_in, lsb_cdb_alias_in, ex_rd_out;
   logic [31:0] disp_pc_in, disp_imm_in, disp_vj_in, disp_vk_in, alu_cdb_value_in, lsb_cdb_value_in;
   logic alu_cdb_valid_in, lsb_cdb_valid_in, full_out;
   logic [31:0] ex_pc_out, ex_rs1_out, ex_rs2_out, ex_imm_out;
   int cmp = 0, errs = 0;

   rs_alu dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .disp_valid_in(disp_valid_in), .disp_optype_in(disp_optype_in), .disp_rd_in(disp_rd_in),
      .disp_pc_in(disp_pc_in), .disp_imm_in(disp_imm_in), .disp_vj_in(disp_vj_in),
      .disp_vk_in(disp_vk_in), .disp_qj_rdy_in(disp_qj_rdy_in), .disp_qk_rdy_in(disp_qk_rdy_in),
      .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in),
      .alu_cdb_valid_in(alu_cdb_valid_in), .alu_cdb_alias_in(alu_cdb_alias_in),
      .alu_cdb_value_in(alu_cdb_value_in), .lsb_cdb_valid_in(lsb_cdb_valid_in),
      .lsb_cdb_alias_in(lsb_cdb_alias_in), .lsb_cdb_value_in(lsb_cdb_value_in),
      .full_out(full_out), .ex_optype_out(ex_optype_out), .ex_rd_out(ex_rd_out),
      .ex_pc_out(ex_pc_out), .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .ex_imm_out(ex_imm_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      disp_valid_in = 1'b0; disp_optype_in = NOP; disp_rd_in = '0; disp_pc_in = '0; disp_imm_in = '0;
      disp_vj_in = '0; disp_vk_in = '0; disp_qj_rdy_in = 1'b0; disp_qk_rdy_in = 1'b0;
      disp_qj_in = '0; disp_qk_in = '0;
      alu_cdb_valid_in = 1'b0; alu_cdb_alias_in = '0; alu_cdb_value_in = '0;
      lsb_cdb_valid_in = 1'b0; lsb_cdb_alias_in = '0; lsb_cdb_value_in = '0;
   endtask

   task automatic disp(input opcode_type_t op, input rob_id_t rd, input logic [31:0] vj, input logic jr,
                       input rob_id_t qj, input logic [31:0] vk, input logic kr, input rob_id_t qk,
                       input logic [31:0] imm);
      disp_valid_in = 1'b1; disp_optype_in = op; disp_rd_in = rd; disp_pc_in = 32'h100 + 32'(rd);
      disp_vj_in = vj; disp_qj_rdy_in = jr; disp_qj_in = qj;
      disp_vk_in = vk; disp_qk_rdy_in = kr; disp_qk_in = qk; disp_imm_in = imm;
   endtask

   initial begin
      idle();
      tick(); tick();
      rst_n_in = 1'b1;
      // 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         chk("reset_op", ex_optype_out, NOP);
         chk("reset_full", full_out, 0);
         tick();
      end
      // 2: ADDI both ready
      disp(OPTYPE_ADDI, 4'd3, 32'd5, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd7);
      tick(); idle();
      chk("addi_wait", ex_optype_out, NOP);
      tick();
      chk("addi_op", ex_optype_out, OPTYPE_ADDI);
      chk("addi_rd", ex_rd_out, 3);
      chk("addi_rs1", ex_rs1_out, 5);
      chk("addi_imm", ex_imm_out, 7);
      chk("addi_pc", ex_pc_out, 32'h103);
      chk("addi_result", ex_rs1_out + ex_imm_out, 12);
      tick();
      chk("addi_after", ex_optype_out, NOP);
      // 3: ADD waiting on alias 5
      disp(OPTYPE_ADD, 4'd2, 32'd0, 1'b0, 4'd5, 32'd3, 1'b1, 4'd0, 32'd0);
      tick(); idle();
      chk("add_wait0", ex_optype_out, NOP);
      tick();
      chk("add_wait1", ex_optype_out, NOP);
      alu_cdb_valid_in = 1'b1; alu_cdb_alias_in = 4'd5; alu_cdb_value_in = 32'h10;
      tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
      chk("add_not_yet", ex_optype_out, NOP);
      tick();
`endif
      chk("add_op", ex_optype_out, OPTYPE_ADD);
      chk("add_rd", ex_rd_out, 2);
      chk("add_rs1", ex_rs1_out, 32'h10);
      chk("add_rs2", ex_rs2_out, 3);
      tick();
      chk("add_after", ex_optype_out, NOP);
      // 4: fill on alias 9, overflow dispatch dropped, drain in index order
      for (int i = 0; i < 8; i++) begin
         chk("fill_notfull", full_out, 0);
         disp(OPTYPE_ADD, rob_id_t'(i), 32'd0, 1'b0, 4'd9, 32'h20 + 32'(i), 1'b1, 4'd0, 32'd0);
         tick();
      end
      disp(OPTYPE_ADDI, 4'd15, 32'd1, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd1);
      chk("full", full_out, 1);
      tick(); idle();
      chk("full_hold", full_out, 1);
      chk("drop_op0", ex_optype_out, NOP);
      tick();
      chk("drop_op1", ex_optype_out, NOP);
      lsb_cdb_valid_in = 1'b1; lsb_cdb_alias_in = 4'd9; lsb_cdb_value_in = 32'd1;
      tick(); idle();
`ifndef RS_WAKEUP_BYPASS_EN
      chk("drain_wait", ex_optype_out, NOP);
      tick();
`endif
      for (int i = 0; i < 8; i++) begin
         chk("drain_op", ex_optype_out, OPTYPE_ADD);
         chk("drain_rd", ex_rd_out, i);
         chk("drain_rs1", ex_rs1_out, 1);
         chk("drain_rs2", ex_rs2_out, 32'h20 + 32'(i));
         chk("drain_full", full_out, 0);
         tick();
      end
      chk("drain_done", ex_optype_out, NOP);
      // 5: clear with same-cycle dispatch
      for (int i = 0; i < 4; i++) begin
         disp(OPTYPE_SUB, rob_id_t'(i), 32'd0, 1'b0, 4'd12, 32'd0, 1'b0, 4'd12, 32'd0);
         tick();
      end
      idle();
      tick();
      chk("clr_pre", ex_optype_out, NOP);
      disp(OPTYPE_ADDI, 4'd7, 32'd1, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd1);
      clear_in = 1'b1;
      tick(); idle(); clear_in = 1'b0;
      chk("clr_op", ex_optype_out, NOP);
      chk("clr_full", full_out, 0);
      tick();
      chk("clr_lost", ex_optype_out, NOP);
      alu_cdb_valid_in = 1'b1; alu_cdb_alias_in = 4'd12; alu_cdb_value_in = 32'd4;
      tick(); idle();
      tick();
      chk("clr_freed0", ex_optype_out, NOP);
      tick();
      chk("clr_freed1", ex_optype_out, NOP);
      // 6: rdy_in low holds a ready entry
      disp(OPTYPE_ADDI, 4'd6, 32'h21, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd1);
      tick(); idle();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_op", ex_optype_out, NOP);
      end
      rdy_in = 1'b1;
      tick();
      chk("resume_op", ex_optype_out, OPTYPE_ADDI);
      chk("resume_rd", ex_rd_out, 6);
      chk("resume_rs1", ex_rs1_out, 32'h21);
      tick();
      chk("resume_after", ex_optype_out, NOP);
      // async reset mid-operation
      disp(OPTYPE_XORI, 4'd5, 32'h3, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'h5);
      tick(); idle();
      tick();
      chk("prerst_op", ex_optype_out, OPTYPE_XORI);
      #2 rst_n_in = 1'b0;
      #1;
      chk("arst_op", ex_optype_out, NOP);
      chk("arst_rd", ex_rd_out, 0);
      chk("arst_rs1", ex_rs1_out, 0);
      chk("arst_full", full_out, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
